// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the hazard scoreboard: in-flight tag slots and EX operand-select codes.
package hazard_pkg;

  localparam int HAZ_AW = 5;
  localparam logic [HAZ_AW-1:0] R0 = '0;

  typedef struct packed {
    logic              valid;
    logic [HAZ_AW-1:0] dest;
    logic              load;
  } tag_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2,
    FWD_TAP = 2'd3
  } fwd_sel_e;

  // match is {ex, mem, wb}; the youngest producer wins
  function automatic fwd_sel_e pickFwd(input logic [2:0] match);
    fwd_sel_e sel;
    sel = FWD_RF;
    if (match[2])      sel = FWD_MEM;
    else if (match[1]) sel = FWD_WB;
    else if (match[0]) sel = FWD_TAP;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage issue request and scheduler response bundle between decode and the hazard scoreboard.
interface hazard_scoreboard_if #(
  parameter int AW       = hazard_pkg::HAZ_AW,
  parameter int STALL_CW = 16
);

  logic                id_valid_x70;
  logic [AW-1:0]       id_src1_x70;
  logic [AW-1:0]       id_src2_x70;
  logic                id_src2_used_x70;
  logic [AW-1:0]       id_dest_x70;
  logic                id_wr_x70;
  logic                id_load_x70;
  logic                flush_x70;
  logic                stall_x70;
  logic [1:0]          fwd_sel_a_x70;
  logic [1:0]          fwd_sel_b_x70;
  logic [STALL_CW-1:0] stall_count_x70;

  modport master (
    output id_valid_x70, id_src1_x70, id_src2_x70, id_src2_used_x70,
           id_dest_x70, id_wr_x70, id_load_x70, flush_x70,
    input  stall_x70, fwd_sel_a_x70, fwd_sel_b_x70, stall_count_x70
  );

  modport slave (
    input  id_valid_x70, id_src1_x70, id_src2_x70, id_src2_used_x70,
           id_dest_x70, id_wr_x70, id_load_x70, flush_x70,
    output stall_x70, fwd_sel_a_x70, fwd_sel_b_x70, stall_count_x70
  );

endinterface

// File: rtl/hazard_scoreboard_cmp.sv
// Compares one source register against the ex/mem/wb tag slots; R0 never matches.
module hazard_cmp
  import hazard_pkg::*;
(
  input  logic [HAZ_AW-1:0] src_i,
  input  tag_t              ex_i,
  input  tag_t              mem_i,
  input  tag_t              wb_i,
  output logic [2:0]        match_o
);

  logic srcLive;

  assign srcLive = (src_i != R0);

  assign match_o = {srcLive & ex_i.valid  & (ex_i.dest  == src_i),
                    srcLive & mem_i.valid & (mem_i.dest == src_i),
                    srcLive & wb_i.valid  & (wb_i.dest  == src_i)};

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue/stall and EX forwarding scheduler for the 5-stage pipeline.
// Define HAZ_FWD_EN for forwarding (load-use interlock only); otherwise stall until the producer leaves WB.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int AW       = HAZ_AW,
  parameter int STALL_CW = 16
) (
  input  logic                clk_x70,
  input  logic                rst_n_x70,
  hazard_scoreboard_if.slave  bus
);

  tag_t                exTag_q, memTag_q, wbTag_q;
  tag_t                exTag_d;
  fwd_sel_e            fwdA_q, fwdB_q, fwdA_d, fwdB_d;
  logic [STALL_CW-1:0] stallCount_q, stallCount_d;
  logic [AW-1:0]       idSrc1, idSrc2;
  logic [2:0]          matchA, matchB, matchBRaw;
  logic                hazard, stall, issue;
  logic                unusedLoadBits;

  assign idSrc1 = bus.id_src1_x70;
  assign idSrc2 = bus.id_src2_x70;

  hazard_cmp cmpA (
    .src_i   (idSrc1),
    .ex_i    (exTag_q),
    .mem_i   (memTag_q),
    .wb_i    (wbTag_q),
    .match_o (matchA)
  );

  hazard_cmp cmpB (
    .src_i   (idSrc2),
    .ex_i    (exTag_q),
    .mem_i   (memTag_q),
    .wb_i    (wbTag_q),
    .match_o (matchBRaw)
  );

  // An immediate operand B can never create a dependency
  assign matchB = bus.id_src2_used_x70 ? matchBRaw : 3'b000;

`ifdef HAZ_FWD_EN
  assign hazard = exTag_q.load & (matchA[2] | matchB[2]);
`else
  assign hazard = |(matchA | matchB);
`endif

  // Flush dominates: the ID instruction is dead, so it neither stalls nor issues
  assign stall = bus.id_valid_x70 & ~bus.flush_x70 & hazard;
  assign issue = bus.id_valid_x70 & ~bus.flush_x70 & ~stall;

  // The load flag is only consulted while the producer sits in EX
  assign unusedLoadBits = ^{exTag_q.load, memTag_q.load, wbTag_q.load};

  always_comb begin
    exTag_d      = '0;
    fwdA_d       = FWD_RF;
    fwdB_d       = FWD_RF;
    stallCount_d = stallCount_q;
    if (issue) begin
      exTag_d.valid = bus.id_wr_x70 & (bus.id_dest_x70 != R0);
      exTag_d.dest  = bus.id_dest_x70;
      exTag_d.load  = bus.id_load_x70;
`ifdef HAZ_FWD_EN
      fwdA_d = pickFwd(matchA);
      fwdB_d = pickFwd(matchB);
`endif
    end
    if (stall && (stallCount_q != '1)) begin
      stallCount_d = stallCount_q + 1'b1;
    end
  end

  always_ff @(posedge clk_x70 or negedge rst_n_x70) begin
    if (!rst_n_x70) begin
      exTag_q      <= '0;
      memTag_q     <= '0;
      wbTag_q      <= '0;
      fwdA_q       <= FWD_RF;
      fwdB_q       <= FWD_RF;
      stallCount_q <= '0;
    end else begin
      exTag_q      <= exTag_d;
      memTag_q     <= exTag_q;
      wbTag_q      <= memTag_q;
      fwdA_q       <= fwdA_d;
      fwdB_q       <= fwdB_d;
      stallCount_q <= stallCount_d;
    end
  end

  assign bus.stall_x70       = stall;
  assign bus.fwd_sel_a_x70   = fwdA_q;
  assign bus.fwd_sel_b_x70   = fwdB_q;
  assign bus.stall_count_x70 = stallCount_q;

endmodule
